// File: rtl/watchdog_scheduler.sv
// Round-robin scheduler sharing one timeout counter across N self-checking requesters.
// Optional window restart (kick) is compiled in with the WDT_KICK_EN macro.
module watchdog_scheduler #(
  parameter int N        = 4,
  parameter int TIMEOUT  = 2400,
  parameter int MAX_FAIL = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  input  logic [N-1:0]         ok,
  input  logic [N-1:0]         kick,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic [$clog2(N)-1:0] cur_id,
  output logic [N-1:0]         err,
  output logic                 fault
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int FW  = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, VERDICT} state_t;

  state_t         state_reg;
  logic [N-1:0]   grant_reg;
  logic           busy_reg;
  logic [IDW-1:0] cur_reg;
  logic [IDW-1:0] rr_reg;
  logic [CW-1:0]  cnt_reg;
  logic           pass_reg;
  logic           fault_reg;
  logic [N-1:0]   err_vec;

  // Rotate the eligible set so the rr pointer sits at bit 0; the lowest set bit wins.
  logic [N-1:0]   elig;
  logic [N-1:0]   rot;
  logic           pick_valid;
  logic [IDW-1:0] pick_off;
  logic [IDW:0]   pick_sum;
  logic [IDW-1:0] pick_id;

  assign elig = req & ~err_vec;
  assign rot  = N'({elig, elig} >> rr_reg);

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick_valid = 1'b1;
        pick_off   = IDW'(i);
      end
    end
  end

  assign pick_sum = {1'b0, rr_reg} + {1'b0, pick_off};
  assign pick_id  = (pick_sum >= (IDW+1)'(N)) ? IDW'(pick_sum - (IDW+1)'(N)) : IDW'(pick_sum);

`ifndef WDT_KICK_EN
  logic kick_unused;
  assign kick_unused = ^kick;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
      cur_reg   <= '0;
      rr_reg    <= '0;
      cnt_reg   <= '0;
      pass_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= |err_vec;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            cur_reg   <= pick_id;
            busy_reg  <= 1'b1;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          grant_reg <= N'(1) << cur_reg;
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // done beats both kick and the final window cycle
          if (done[cur_reg]) begin
            pass_reg  <= ok[cur_reg];
            state_reg <= VERDICT;
          end
`ifdef WDT_KICK_EN
          else if (kick[cur_reg]) begin
            cnt_reg <= '0;
          end
`endif
          else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            pass_reg  <= 1'b0;
            state_reg <= VERDICT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        VERDICT: begin
          grant_reg <= '0;
          busy_reg  <= 1'b0;
          rr_reg    <= (cur_reg == IDW'(N - 1)) ? '0 : cur_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-channel consecutive-failure counter and sticky error flag.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [FW-1:0] fail_reg;
      logic          err_reg;
      logic          verdict_here;

      assign verdict_here = (state_reg == VERDICT) && (cur_reg == IDW'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          fail_reg <= '0;
          err_reg  <= 1'b0;
        end else if (verdict_here) begin
          if (pass_reg) begin
            fail_reg <= '0;
          end else if (fail_reg != FW'(MAX_FAIL)) begin
            fail_reg <= fail_reg + 1'b1;
            if (fail_reg == FW'(MAX_FAIL - 1))
              err_reg <= 1'b1;
          end
        end
      end

      assign err_vec[gi] = err_reg;
    end
  endgenerate

  assign grant  = grant_reg;
  assign busy   = busy_reg;
  assign cur_id = cur_reg;
  assign err    = err_vec;
  assign fault  = fault_reg;

endmodule
